mimo_phase_sequencer: RTL

MIMO_PHASE_SEQUENCER -- requirements
Module: mimo_phase_sequencer

---
 rtl/mimo_phase_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mimo_phase_sequencer.sv
// mimo_phase_sequencer
//
// Steps a phase index through NUM_PHASES phases. Each phase is held for
// dwell_len+1 cycles. The index ascends or descends, and the block runs one
// pass or loops continuously. All outputs come straight from registers.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high reset
//   start        : begin a sequence (only looked at in IDLE)
//   stop         : abort back to IDLE; beats expiry and advance
//   mode_oneshot : 1 = one pass then IDLE, 0 = loop (latched at start)
//   dir_down     : 0 = ascend, 1 = descend (latched at start)
//   dwell_len    : phase length minus one (sampled at every phase entry)
//   phase        : current phase index
//   busy         : high while in RUN
//   phase_start  : one-cycle pulse in the first cycle of each phase
//   seq_done     : one-cycle pulse when a full pass completes
//   state_dbg    : current FSM state (0 = IDLE, 1 = RUN) for observation
//
// Handshake: start and stop are level-sampled request inputs, with no ready
// return. A start is accepted on any edge where the block is IDLE, start=1
// and stop=0. Starts seen in RUN are dropped.
module mimo_phase_sequencer #(
    parameter int NUM_PHASES = 3,
    parameter int DWELL_W    = 8,
    localparam int PH_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_oneshot,
    input  logic               dir_down,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [PH_W-1:0]    phase,
    output logic               busy,
    output logic               phase_start,
    output logic               seq_done,
    output logic               state_dbg
);

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               ps_q, ps_d;
    logic               sd_q, sd_d;
    logic               oneshot_q, oneshot_d;
    logic               down_q, down_d;

    // Pass boundaries for the latched direction.
    logic [PH_W-1:0]    first_ph;
    logic [PH_W-1:0]    last_ph;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            ps_q      <= 1'b0;
            sd_q      <= 1'b0;
            oneshot_q <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            ps_q      <= ps_d;
            sd_q      <= sd_d;
            oneshot_q <= oneshot_d;
            down_q    <= down_d;
        end
    end

    // Next-state logic. It also computes the next value of every
    // registered output.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        ps_d      = 1'b0;
        sd_d      = 1'b0;
        oneshot_d = oneshot_q;
        down_d    = down_q;
        first_ph  = down_q ? LAST_PH : '0;
        last_ph   = down_q ? '0 : LAST_PH;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                cnt_d   = '0;
                if (start && !stop) begin
                    state_d   = RUN;
                    oneshot_d = mode_oneshot;
                    down_d    = dir_down;
                    // Use the raw input here: down_q does not hold the new
                    // direction until after this edge.
                    phase_d   = dir_down ? LAST_PH : '0;
                    cnt_d     = dwell_len;
                    ps_d      = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (phase_q == last_ph) begin
                        sd_d = 1'b1;
                        if (oneshot_q) begin
                            state_d = IDLE;
                            phase_d = '0;
                        end else begin
                            phase_d = first_ph;
                            cnt_d   = dwell_len;
                            ps_d    = 1'b1;
                        end
                    end else begin
                        // The wrap case is taken by the last-phase branch
                        // above, so a plain +/-1 is enough here.
                        phase_d = down_q ? (phase_q - PH_W'(1)) : (phase_q + PH_W'(1));
                        cnt_d   = dwell_len;
                        ps_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. Every output is a direct copy of a register.
    always_comb begin
        phase       = phase_q;
        busy        = (state_q == RUN);
        phase_start = ps_q;
        seq_done    = sd_q;
        state_dbg   = state_q;
    end

endmodule
